// File: rtl/approx_mul_pipe_if.sv
// Operand/result handshake bundle for approx_mul_pipe.
// out_err exists only when APPROX_ERR_EN is defined.
interface approx_mul_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [3:0]           in_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_prod;
`ifdef APPROX_ERR_EN
    logic [2*WIDTH-1:0]   out_err;

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out_prod, out_err
    );

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out_prod, out_err
    );
`else
    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out_prod
    );

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out_prod
    );
`endif
endinterface

// File: rtl/approx_mul_pipe.sv
// Three-stage quadrant-split approximate multiplier with valid/ready on both sides.
// Define APPROX_ERR_EN to carry the exact product alongside and report out_err.
module approx_mul_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TRUNC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    approx_mul_pipe_if.slave  bus
);
    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned P  = 2 * H;
    localparam int unsigned W2 = 2 * WIDTH;
    localparam logic [P-1:0] TRUNC_MASK = ~P'((64'd1 << TRUNC) - 64'd1);

    // Quadrant product, optionally with its low TRUNC bits dropped
    function automatic logic [P-1:0] quad(input logic [H-1:0] x,
                                          input logic [H-1:0] y,
                                          input logic         trunc);
        logic [P-1:0] p;
        p = P'(x) * P'(y);
        return trunc ? (p & TRUNC_MASK) : p;
    endfunction

    logic              s1_valid_q, s1_valid_d;
    logic              s2_valid_q, s2_valid_d;
    logic              s3_valid_q, s3_valid_d;
    logic              s1_ready_c, s2_ready_c, s3_ready_c;
    logic              s1_load_c,  s2_load_c,  s3_load_c;

    logic [WIDTH-1:0]  s1_a_q, s1_b_q;
    logic [3:0]        s1_mode_q;
    logic [P-1:0]      s2_ll_q, s2_lh_q, s2_hl_q, s2_hh_q;
    logic [P-1:0]      ll_c, lh_c, hl_c, hh_c;
    logic [W2-1:0]     sum_c;
    logic [W2-1:0]     out_prod_q;

    // A stage may take new data when it is empty or its content moves on this cycle
    assign s3_ready_c = !s3_valid_q || bus.out_ready;
    assign s2_ready_c = !s2_valid_q || s3_ready_c;
    assign s1_ready_c = !s1_valid_q || s2_ready_c;

    assign s1_load_c  = bus.in_valid && s1_ready_c;
    assign s2_load_c  = s1_valid_q   && s2_ready_c;
    assign s3_load_c  = s2_valid_q   && s3_ready_c;

    assign bus.in_ready  = s1_ready_c;
    assign bus.out_valid = s3_valid_q;
    assign bus.out_prod  = out_prod_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s3_valid_d = s3_valid_q;
        if (s1_ready_c) s1_valid_d = bus.in_valid;
        if (s2_ready_c) s2_valid_d = s1_valid_q;
        if (s3_ready_c) s3_valid_d = s2_valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
        end
    end

    // Quadrant products from captured operands; mode bit 1 pairs al with bh
    always_comb begin
        ll_c = quad(s1_a_q[H-1:0], s1_b_q[H-1:0], s1_mode_q[0]);
        lh_c = quad(s1_a_q[H-1:0], s1_b_q[P-1:H], s1_mode_q[1]);
        hl_c = quad(s1_a_q[P-1:H], s1_b_q[H-1:0], s1_mode_q[2]);
        hh_c = quad(s1_a_q[P-1:H], s1_b_q[P-1:H], s1_mode_q[3]);
    end

    always_comb begin
        sum_c = W2'(s2_ll_q)
              + (W2'(s2_lh_q) << H)
              + (W2'(s2_hl_q) << H)
              + (W2'(s2_hh_q) << P);
    end

    always_ff @(posedge clk) begin
        if (s1_load_c) begin
            s1_a_q    <= bus.in_a;
            s1_b_q    <= bus.in_b;
            s1_mode_q <= bus.in_mode;
        end
        if (s2_load_c) begin
            s2_ll_q <= ll_c;
            s2_lh_q <= lh_c;
            s2_hl_q <= hl_c;
            s2_hh_q <= hh_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_prod_q <= '0;
        end else if (s3_load_c) begin
            out_prod_q <= sum_c;
        end
    end

`ifdef APPROX_ERR_EN
    logic [W2-1:0] s2_exact_q;
    logic [W2-1:0] out_err_q;

    // Exact product rides one stage behind the operands, level with the quadrants
    always_ff @(posedge clk) begin
        if (s2_load_c) begin
            s2_exact_q <= W2'(s1_a_q) * W2'(s1_b_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_err_q <= '0;
        end else if (s3_load_c) begin
            out_err_q <= s2_exact_q - sum_c;
        end
    end

    assign bus.out_err = out_err_q;
`endif

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Scoreboard bench for approx_mul_pipe: 8-bit instance for flow control and
// arithmetic, 16-bit instance for the wide truncation corner.
module tb_approx_mul_pipe;
    localparam int unsigned W   = 8;
    localparam int unsigned T   = 2;
    localparam int unsigned W16 = 16;
    localparam int unsigned T16 = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    approx_mul_pipe_if #(.WIDTH(W))   bus8 ();
    approx_mul_pipe_if #(.WIDTH(W16)) bus16 ();

    approx_mul_pipe #(.WIDTH(W),   .TRUNC(T))   dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    approx_mul_pipe #(.WIDTH(W16), .TRUNC(T16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    typedef struct {
        logic [15:0] prod;
        logic [15:0] err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   n_out  = 0;

    // Error contributed by the dropped low bits of each truncated quadrant
    function automatic logic [15:0] ref_err(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] mode);
        logic [3:0]  al, ah, bl, bh;
        logic [7:0]  q, lo_mask;
        logic [15:0] e;
        al = a[3:0]; ah = a[7:4]; bl = b[3:0]; bh = b[7:4];
        lo_mask = 8'((1 << T) - 1);
        e = 16'd0;
        if (mode[0]) begin q = 8'(al) * 8'(bl); e = e + 16'(q & lo_mask); end
        if (mode[1]) begin q = 8'(al) * 8'(bh); e = e + (16'(q & lo_mask) << 4); end
        if (mode[2]) begin q = 8'(ah) * 8'(bl); e = e + (16'(q & lo_mask) << 4); end
        if (mode[3]) begin q = 8'(ah) * 8'(bh); e = e + (16'(q & lo_mask) << 8); end
        return e;
    endfunction

    function automatic exp_t ref_model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] mode);
        exp_t r;
        r.err  = ref_err(a, b, mode);
        r.prod = (16'(a) * 16'(b)) - r.err;
        return r;
    endfunction

    // Output monitor: every output transfer pops and checks the scoreboard
    always @(negedge clk) begin
        if (rst_n && bus8.out_valid && bus8.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got out_prod=%h with empty scoreboard", bus8.out_prod);
            end else begin
                mon_e = sb.pop_front();
                if (bus8.out_prod !== mon_e.prod) begin
                    errors++;
                    $display("FAIL sb_prod: got %h expected %h", bus8.out_prod, mon_e.prod);
                end
`ifdef APPROX_ERR_EN
                checks++;
                if (bus8.out_err !== mon_e.err) begin
                    errors++;
                    $display("FAIL sb_err: got %h expected %h", bus8.out_err, mon_e.err);
                end
`endif
            end
            n_out++;
        end
    end

    // Present one operation and hold it until accepted; returns cycles taken
    task automatic drive_op(input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] m, output int waits);
        logic acc;
        #1;
        bus8.in_valid = 1'b1;
        bus8.in_a     = a;
        bus8.in_b     = b;
        bus8.in_mode  = m;
        waits = 0;
        acc   = 1'b0;
        while (!acc && waits < 100) begin
            @(negedge clk);
            acc = bus8.in_ready;
            if (acc) sb.push_back(ref_model(a, b, m));
            @(posedge clk);
            waits++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout: in_ready stayed %b, required 1", bus8.in_ready);
        end
    endtask

    task automatic idle8();
        #1;
        bus8.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus8.in_valid = 1'b0; bus8.in_a = '0; bus8.in_b = '0; bus8.in_mode = '0;
        bus8.out_ready = 1'b1;
        bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0; bus16.in_mode = '0;
        bus16.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus8.out_valid); end
        checks++; if (bus8.out_prod !== 16'h0) begin errors++; $display("FAIL rst_out_prod: got %h expected 0000", bus8.out_prod); end
        checks++; if (bus16.out_prod !== 32'h0) begin errors++; $display("FAIL rst_out_prod16: got %h expected 0", bus16.out_prod); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", bus8.in_ready); end
        checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid: got %b expected 0", bus8.out_valid); end
    endtask

    task automatic test_latency();
        int w, n;
        @(posedge clk);
        drive_op(8'h12, 8'h34, 4'b0000, w);
        idle8();
        checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL lat_early: out_valid=%b expected 0", bus8.out_valid); end
        n = 1;
        while (n < 10 && bus8.out_valid !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL lat_cycles: got %0d expected 3", n); end
        checks++; if (bus8.out_prod !== 16'h03A8) begin errors++; $display("FAIL lat_prod: got %h expected 03a8", bus8.out_prod); end
`ifdef APPROX_ERR_EN
        checks++; if (bus8.out_err !== 16'h0) begin errors++; $display("FAIL lat_err: got %h expected 0000", bus8.out_err); end
`endif
        repeat (2) @(posedge clk);
    endtask

    task automatic test_corners();
        int w, got;
        logic [15:0] pv [2];
        logic [15:0] ev [2];
        @(posedge clk);
        drive_op(8'hFF, 8'hFF, 4'b0001, w);
        drive_op(8'hFF, 8'hFF, 4'b1111, w);
        idle8();
        got = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (bus8.out_valid && got < 2) begin
`ifdef APPROX_ERR_EN
                ev[got] = bus8.out_err;
`else
                ev[got] = 16'h0;
`endif
                pv[got] = bus8.out_prod;
                got++;
            end
        end
        checks++; if (got != 2) begin errors++; $display("FAIL corner_count: got %0d expected 2", got); end
        checks++; if (pv[0] !== 16'hFE00) begin errors++; $display("FAIL corner_ll: got %h expected fe00", pv[0]); end
        checks++; if (pv[1] !== 16'hFCE0) begin errors++; $display("FAIL corner_all: got %h expected fce0", pv[1]); end
`ifdef APPROX_ERR_EN
        checks++; if (ev[1] !== 16'h0121) begin errors++; $display("FAIL corner_err: got %h expected 0121", ev[1]); end
`endif
    endtask

    task automatic test_back_to_back();
        int w, n0;
        @(posedge clk);
        bus8.out_ready = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 16; i++) begin
            drive_op(8'($urandom), 8'($urandom), 4'(i), w);
            checks++;
            if (w != 1) begin errors++; $display("FAIL b2b_accept[%0d]: took %0d cycles expected 1", i, w); end
        end
        idle8();
        repeat (5) @(posedge clk);
        checks++; if (n_out - n0 != 16) begin errors++; $display("FAIL b2b_count: got %0d expected 16", n_out - n0); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_left: %0d pending expected 0", sb.size()); end
    endtask

    // Stream with out_ready low; count accepts, watch the held output
    task automatic stream_stalled(input int cycles, output int accepts,
                                  output logic held_seen, output logic stable,
                                  output logic [15:0] held);
        logic acc;
        accepts = 0; held_seen = 1'b0; stable = 1'b1; held = '0;
        #1;
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 1'b1;
        bus8.in_a = 8'($urandom); bus8.in_b = 8'($urandom); bus8.in_mode = 4'($urandom);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            acc = bus8.in_ready;
            if (acc) begin
                sb.push_back(ref_model(bus8.in_a, bus8.in_b, bus8.in_mode));
                accepts++;
            end
            if (bus8.out_valid) begin
                if (!held_seen) begin held = bus8.out_prod; held_seen = 1'b1; end
                else if (bus8.out_prod !== held) stable = 1'b0;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                bus8.in_a = 8'($urandom); bus8.in_b = 8'($urandom); bus8.in_mode = 4'($urandom);
            end
        end
    endtask

    task automatic test_stall();
        int acc_n, n0;
        logic seen, stable;
        logic [15:0] held, first_exp;
        @(posedge clk);
        n0 = n_out;
        stream_stalled(10, acc_n, seen, stable, held);
        first_exp = (sb.size() > 0) ? sb[0].prod : 16'hxxxx;
        checks++; if (acc_n != 3) begin errors++; $display("FAIL stall_accepts: got %0d expected 3", acc_n); end
        checks++; if (bus8.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", bus8.in_ready); end
        checks++; if (seen !== 1'b1 || stable !== 1'b1) begin errors++; $display("FAIL stall_hold: seen=%b stable=%b expected 1 1", seen, stable); end
        checks++; if (held !== first_exp) begin errors++; $display("FAIL stall_held_val: got %h expected %h", held, first_exp); end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        checks++; if (n_out - n0 != 3) begin errors++; $display("FAIL stall_drain: got %0d outputs expected 3", n_out - n0); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL stall_left: %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid_stall();
        int acc_n, n0;
        logic seen, stable, stale;
        logic [15:0] held;
        @(posedge clk);
        stream_stalled(6, acc_n, seen, stable, held);
        bus8.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", bus8.out_valid); end
        checks++; if (bus8.out_prod !== 16'h0) begin errors++; $display("FAIL arst_prod: got %h expected 0000", bus8.out_prod); end
        checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %b expected 1", bus8.in_ready); end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus8.out_ready = 1'b1;
        n0 = n_out;
        stale = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (bus8.out_valid) stale = 1'b1;
        end
        checks++; if (stale !== 1'b0 || n_out != n0) begin errors++; $display("FAIL arst_stale: stale=%b outputs=%0d expected 0 0", stale, n_out - n0); end
    endtask

    task automatic test_wide();
        int n;
        @(posedge clk);
        #1;
        bus16.in_valid = 1'b1;
        bus16.in_a = 16'hFFFF; bus16.in_b = 16'hFFFF; bus16.in_mode = 4'b1111;
        @(negedge clk);
        checks++; if (bus16.in_ready !== 1'b1) begin errors++; $display("FAIL wide_ready: got %b expected 1", bus16.in_ready); end
        @(posedge clk);
        #1;
        bus16.in_valid = 1'b0;
        n = 0;
        while (n < 10 && bus16.out_valid !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (bus16.out_prod !== 32'hFFFCFE00) begin errors++; $display("FAIL wide_prod: got %h expected fffcfe00", bus16.out_prod); end
`ifdef APPROX_ERR_EN
        checks++; if (bus16.out_err !== 32'h00010201) begin errors++; $display("FAIL wide_err: got %h expected 00010201", bus16.out_err); end
`endif
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_corners();
        test_back_to_back();
        test_stall();
        test_reset_mid_stall();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/approx_mul_pipe.md
Name: approx_mul_pipe

Overview:
- Parametrised, pipelined successor of the 8x8 quadrant-split approximate multiplier.
- Splits unsigned WIDTH x WIDTH operands into four half-width quadrant products: LL, LH, HL, HH.
- Each quadrant runs exact or truncated, selected per operation by a 4-bit mode word.
- Sits between operand producers and accumulators/datapaths, with valid/ready flow control on both sides.

Parameters:
- WIDTH, 8, operand width; even, 4..32; half width H = WIDTH/2.
- TRUNC, 2, low bits zeroed in a truncated quadrant product; 0..H.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and mode valid
- in_ready  out  1  block accepts this cycle
- in_a  in  WIDTH  multiplicand, unsigned
- in_b  in  WIDTH  multiplier, unsigned
- in_mode  in  4  bit0 LL, bit1 LH (al*bh), bit2 HL (ah*bl), bit3 HH; 1 = truncated
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_prod  out  2*WIDTH  approximate product

Behaviour:
- Transfer rules: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Pipeline, 3 register stages:
  - S1 captures a, b and mode.
  - S2 holds the four H x H quadrant products, each 2H bits. Truncated quadrant: product & ~((1<<TRUNC)-1).
  - S3 holds the sum LL + (LH<<H) + (HL<<H) + (HH<<2H), computed at full 2*WIDTH width, no overflow possible.
- Latency: exactly 3 cycles from input transfer to out_valid with no backpressure. Throughput 1 per cycle.
- Stall: stage k advances when stage k+1 is empty or advancing; S3 advances when out_valid & out_ready.
- in_ready = !S1_valid | S1_advances. Combinational from out_ready through the stage valids; no combinational in->out data path.
- Holding: while out_valid & !out_ready, out_prod and out_valid stay stable. Bubbles collapse: an empty stage fills even when downstream is stalled.
- Mode travels with its operands. A mode change between back-to-back operations takes effect per operation, with no flush.
- mode = 4'b0000 yields the exact product.
- Reset, asynchronous assert: all stage valids clear, out_valid = 0, out_prod = 0, in_ready = 1 after reset. In-flight operations are discarded, including on reset mid-stall.
- Data registers need no reset except out_prod.
- Simultaneous accept and output on the same cycle with a full pipeline: both transfers occur, occupancy unchanged.

Optional Feature:
- Macro APPROX_ERR_EN.
- Defined: adds port out_err, out, 2*WIDTH: exact product minus out_prod, non-negative. The exact product is carried in parallel through the same stages, aligned with and held stable with out_prod. In_ready and latency are unchanged.
- Undefined: port and exact path absent; no other behaviour changes.

Test Plan:
- WIDTH=8, TRUNC=2, a=0x12, b=0x34, mode=0 -> out_prod=0x03A8 exactly 3 cycles later; out_err=0.
- a=0xFF, b=0xFF, mode=4'b0001 -> 0xFE00. Mode=4'b1111 -> 0xFCE0, out_err=0x0121.
- 16 back-to-back random operations, out_ready=1, mode cycling 0..15 -> one result per cycle in order, each matching the reference model, mode correctly paired.
- Hold out_ready=0 for 10 cycles while streaming -> in_ready drops after 3 accepts and out_prod stays stable. Release -> no loss or duplication.
- Assert rst_n=0 with a full stalled pipeline -> out_valid=0 and out_prod=0 immediately, asynchronously. Release -> in_ready=1, no stale results emitted.
- WIDTH=16, TRUNC=8, a=b=0xFFFF, mode=4'b1111 -> each quadrant 0xFE01 becomes 0xFE00. Result 0xFFFE0001 - (1 + 2*(1<<8) + (1<<16)) = 0xFFFCFE00.
